// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter granting one shared resource to one of
// WIDTH requesters at a time, with a bounded hold time per grant.
//
// Ports:
//   clk_i      - single clock, rising edge
//   srst_i     - synchronous reset, active high
//   req_i      - per-requester request bits
//   done_i     - current grantee releases the resource this cycle
//   gnt_o      - registered one-hot grant (zero when idle)
//   gnt_idx_o  - registered binary index of the grantee (holds when idle)
//   gnt_val_o  - high while a grant is active
//   timeout_o  - one-cycle pulse when a grant is revoked by the hold limit
//
// Priority: the requester strictly above the last grantee wins first, then
// the search wraps to requester 0. A releasing requester therefore drops to
// lowest priority but is re-granted if it is the only one still asking.

// Per-lane qualifier: keeps a request only if the lane sits strictly above
// the priority base.
module rr_arbiter_lane #(
  parameter int LANE  = 0,
  parameter int IDX_W = 1
) (
  input  logic             req_i,
  input  logic [IDX_W-1:0] base_i,
  output logic             above_req_o
);
  localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(LANE);

  assign above_req_o = req_i & (MY_IDX > base_i);
endmodule

module rr_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 256
) (
  input  logic                                      clk_i,
  input  logic                                      srst_i,
  input  logic [WIDTH-1:0]                          req_i,
  input  logic                                      done_i,
  output logic [WIDTH-1:0]                          gnt_o,
  output logic [(($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1)-1:0] gnt_idx_o,
  output logic                                      gnt_val_o,
  output logic                                      timeout_o
);
  localparam int IDX_W = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [WIDTH-1:0]   gnt_q, gnt_d;
  logic               gnt_val_q, gnt_val_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  // Priority base: in GRANT any re-arbitration happens on a release, and the
  // pointer must already reflect the releasing grantee, so the mask is built
  // from gnt_idx_q directly rather than waiting for ptr_q to update.
  logic [IDX_W-1:0]   base;
  logic [WIDTH-1:0]   above_req;
  logic [IDX_W-1:0]   pick_idx;
  logic               any_req;
  logic               cur_req;
  logic               hold_max;
  logic               release_ev;

  assign base = (state_q == GRANT) ? gnt_idx_q : ptr_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    rr_arbiter_lane #(
      .LANE  (i),
      .IDX_W (IDX_W)
    ) u_lane (
      .req_i       (req_i[i]),
      .base_i      (base),
      .above_req_o (above_req[i])
    );
  end

  function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    pick_idx = (|above_req) ? lowest_set(above_req) : lowest_set(req_i);
  end

  assign any_req  = |req_i;
  assign cur_req  = req_i[gnt_idx_q];
  assign hold_max = (hold_cnt_q == HOLD_LAST);
  // Any one of: explicit done, grantee withdrew, hold limit reached.
  assign release_ev = done_i | ~cur_req | hold_max;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_d      = gnt_q;
    gnt_val_d  = gnt_val_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // done_i has no meaning without a grantee and is ignored here.
        if (any_req) begin
          state_d    = GRANT;
          gnt_idx_d  = pick_idx;
          gnt_d      = WIDTH'(1) << pick_idx;
          gnt_val_d  = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_ev) begin
          ptr_d     = gnt_idx_q;
          // Timeout only when the limit is the sole reason for release;
          // done or withdrawal in the same cycle take precedence.
          timeout_d = hold_max & ~done_i & cur_req;
          if (any_req) begin
            gnt_idx_d  = pick_idx;
            gnt_d      = WIDTH'(1) << pick_idx;
            gnt_val_d  = 1'b1;
            hold_cnt_d = '0;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            gnt_val_d  = 1'b0;
            hold_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_RST;
      gnt_idx_q  <= '0;
      gnt_q      <= '0;
      gnt_val_q  <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_q      <= gnt_d;
      gnt_val_q  <= gnt_val_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = gnt_idx_q;
  assign gnt_val_o = gnt_val_q;
  assign timeout_o = timeout_q;
endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: number of requesters sharing the resource; legal range 2..64.
REQ-002 Parameter MAX_HOLD, default 256: maximum cycles one grant may be held; legal range 2..65535.
REQ-003 Local IDX_W = max(1, $clog2(WIDTH)); CNT_W = $clog2(MAX_HOLD+1).
REQ-004 clk_i  input  1  single clock; all logic samples on its rising edge.
REQ-005 srst_i  input  1  synchronous reset, active-high.
REQ-006 req_i  input  WIDTH  request per requester; bit i = requester i.
REQ-007 done_i  input  1  current grantee releases the resource this cycle.
REQ-008 gnt_o  output  WIDTH  one-hot grant vector, registered.
REQ-009 gnt_idx_o  output  IDX_W  binary index of granted requester, registered.
REQ-010 gnt_val_o  output  1  high while any grant is active.
REQ-011 timeout_o  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-012 The block SHALL use a two-state FSM: IDLE (no grant) and GRANT (one grant held).
REQ-013 Pointer register ptr (IDX_W bits) SHALL hold the index of the last granted requester.
REQ-014 Selection: mask = bits strictly above ptr; if (req_i & mask) != 0, pick lowest set bit of (req_i & mask), else lowest set bit of req_i (wrap-around).
REQ-015 IDLE -> GRANT when req_i != 0; gnt_o, gnt_idx_o, gnt_val_o SHALL assert on the next rising edge (latency 1 cycle).
REQ-016 In GRANT, gnt_o SHALL stay constant until a release event.
REQ-017 Release events: done_i = 1; req_i[gnt_idx_o] = 0 (requester withdrew); hold counter reaching MAX_HOLD.
REQ-018 On release, ptr SHALL load gnt_idx_o, and selection per REQ-014 SHALL be evaluated the same cycle with the updated mask.
REQ-019 If release and any req_i bit is set, the new grant SHALL appear on the next edge (back-to-back, no idle cycle) and the FSM SHALL stay in GRANT.
REQ-020 If release and req_i == 0, the FSM SHALL go to IDLE and gnt_o = 0, gnt_val_o = 0 next cycle.
REQ-021 A releasing requester still requesting SHALL be re-granted only if no other requester is pending (lowest priority after its own release).
REQ-022 Hold counter SHALL clear on every new grant and increment each GRANT cycle without release; at count MAX_HOLD-1 with no other release, the grant is revoked and timeout_o pulses for exactly 1 cycle, aligned with the cycle gnt_o changes.
REQ-023 done_i and a timeout in the same cycle SHALL be treated as done_i (timeout_o stays 0).
REQ-024 done_i while in IDLE SHALL be ignored.
REQ-025 gnt_o SHALL always be zero or one-hot; gnt_idx_o SHALL equal the index of the set bit of gnt_o whenever gnt_val_o = 1 and hold its last value otherwise.
REQ-026 req_i changes on non-granted bits during GRANT SHALL NOT affect gnt_o.

Reset
REQ-027 With srst_i = 1 at a rising edge: FSM = IDLE, gnt_o = 0, gnt_idx_o = 0, gnt_val_o = 0, timeout_o = 0, hold counter = 0, ptr = WIDTH-1 (requester 0 highest priority first).
REQ-028 Reset mid-grant SHALL drop the grant on that same edge; no timeout_o pulse; req_i is ignored during reset.
REQ-029 The first grant after reset deassertion SHALL occur one cycle after req_i != 0 is sampled with srst_i = 0.

Verification (WIDTH=4, MAX_HOLD=8)
REQ-030 Reset, req_i=4'b1010 held, done_i pulsed after each grant -> grants in order 1, 3, 1, 3; each 1 cycle after the previous done_i.
REQ-031 req_i=4'b1111 constant, done_i every 3rd cycle -> grant order 0,1,2,3,0, no idle gap, gnt_o always one-hot.
REQ-032 req_i=4'b0100, no done_i -> gnt_o=4'b0100 for 8 cycles, then timeout_o=1 for 1 cycle, gnt_o re-granted to 2 (only requester).
REQ-033 Grant to 0, requester 0 drops req_i with req_i=0 elsewhere -> gnt_val_o=0 next cycle, timeout_o=0, FSM IDLE.
REQ-034 srst_i asserted during GRANT to requester 2 -> all outputs 0 next edge; after release, req_i=4'b0101 -> grant to 0.
REQ-035 done_i and hold-count expiry in the same cycle -> timeout_o stays 0, next grant per REQ-014.
